inputs_module: RTL and testbench
================================

Name: inputs_module

Overview:
- Input-side counterpart of the output buffer block in the RTE IP.
- Samples 32 asynchronous external input pins, synchronises and debounces each one, and holds a software-visible snapshot.
- Provides single-bit addressed reads for the stack machine (`val` and edge status by `addr`), plus sticky per-pin rise/fall flags.

Parameters:
- WIDTH, 32, number of input pins; `addr` width is $clog2(WIDTH) = 5.
- DB_CYCLES, 4, consecutive stable cycles required before a filtered bit changes; 0 = no debounce.
- SNAP_RST, 32'h0, reset value of the snapshot and filter registers.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- in_pins  in  32  raw asynchronous external inputs
- snap_en  in  1  copy filtered inputs into the snapshot this cycle
- rd_en  in  1  read request for bit `addr`
- addr  in  5  bit index for the read
- clr_edges  in  1  clear all rise/fall flags
- val  out  1  snapshot[addr], registered
- edge_bit  out  1  rise_flag[addr] | fall_flag[addr], registered
- rd_valid  out  1  one-cycle strobe qualifying `val` and `edge_bit`
- in_buf  out  32  current snapshot
- edge_pending  out  1  OR of all rise/fall flags

Behaviour:
- Reset (async, active-high): sync1, sync2, filt and snapshot = SNAP_RST; counters, rise_flag, fall_flag, val, edge_bit and rd_valid = 0. Applying reset mid-debounce discards the partial count.
- Synchroniser: two flops per bit (in_pins -> sync1 -> sync2). Nothing else samples in_pins.
- Debounce, per bit, counter width $clog2(DB_CYCLES+1):
  - If sync2 == filt: counter <= 0.
  - Else if counter == DB_CYCLES-1: filt <= sync2 and counter <= 0.
  - Else: counter <= counter + 1.
  - DB_CYCLES = 0: filt <= sync2 every cycle.
- Latency (DB_CYCLES = 4): a pin change sampled at edge k appears in filt at edge k+5. Any glitch shorter than DB_CYCLES cycles at sync2 is rejected.
- Edge flags:
  - rise_flag[i] is set on the edge where filt[i] goes 0->1; fall_flag[i] on 1->0.
  - Flags are sticky and cleared by clr_edges (all bits) or by a read of that bit (read-to-clear).
  - Set beats clear when both occur in the same cycle.
  - edge_pending is combinational OR of the flag registers.
- Snapshot: snap_en = 1 -> snapshot <= filt. in_buf = snapshot.
- Read:
  - rd_en = 1 at edge n -> at edge n+1, val = snapshot[addr], edge_bit = flags[addr], rd_valid = 1 for exactly one cycle.
  - val and edge_bit hold their value until the next read.
  - Back-to-back reads are allowed, one per cycle.
- Simultaneous events:
  - snap_en with rd_en in the same cycle: the read returns the pre-update snapshot.
  - Read-to-clear together with a new edge on the same bit: edge_bit reports the old flags and the new flag survives.
- addr is always in range (WIDTH = 32), so no out-of-range handling is required.

Decomposition:
- Shared package rte_io_pkg holds:
  - IO_WIDTH = 32 and IO_ADDR_W = 5, shared with outputs_module.
  - DB_CYCLES_DEFAULT.
- One natural sub-module: input_debounce (single bit: 2-flop synchroniser + counter + filt register + rise/fall pulses), instantiated WIDTH times via generate.
- inputs_module holds the flags, snapshot and read path.

Test Plan:
- Reset: hold reset with in_pins = 32'hFFFF_FFFF -> in_buf = 0, val = 0, rd_valid = 0, edge_pending = 0; after release and 6 cycles plus snap_en -> in_buf = 32'hFFFF_FFFF.
- Glitch reject: DB_CYCLES = 4, pulse in_pins[3] high for 3 cycles -> filt[3] stays 0, no rise flag, edge_pending = 0.
- Stable change: set in_pins = 32'h0000_0003 at edge k -> filt changes at edge k+5 (not k+4); at that edge rise_flag[0] = rise_flag[1] = 1 and edge_pending = 1; snap_en then in_buf = 32'h3.
- Read path: snapshot = 32'h8000_0040; rd_en with addr = 6, then addr = 31, then addr = 0 on consecutive cycles -> val = 1, 1, 0 with rd_valid high for 3 cycles; edge_bit returned and cleared per bit.
- Simultaneous: snap_en and rd_en in the same cycle with old snapshot bit = 0 and new = 1 -> val = 0; next read -> val = 1. Read-to-clear of bit 2 in the same cycle as a new fall on bit 2 -> edge_bit = old value and fall_flag[2] = 1 afterwards.
- Reset mid-operation: assert reset 2 cycles into a debounce of bit 5 -> all outputs zero immediately (async); after release the change needs a full 2 + DB_CYCLES cycles again.

Source files
------------

// File: rtl/rte_io_pkg.sv
// Shared constants for the RTE input/output buffer blocks.
package rte_io_pkg;

  localparam int IO_WIDTH          = 32;
  localparam int IO_ADDR_W         = $clog2(IO_WIDTH);
  localparam int DB_CYCLES_DEFAULT = 4;

  // A zero-width counter is illegal, so small debounce settings still get one bit.
  function automatic int db_cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Single-pin conditioner: two-flop synchroniser, stability counter and filtered
// output, with combinational rise/fall pulses aligned to the filter update edge.
module input_debounce
  import rte_io_pkg::*;
#(
  parameter int   DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter logic RST_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic filt,
  output logic rise,
  output logic fall
);

  localparam int              CNT_W    = db_cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = (DB_CYCLES == 0) ? '0 : CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             filt_q,  filt_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = pin;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    if (DB_CYCLES == 0) begin
      filt_d = sync2_q;
    end else if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      filt_q  <= RST_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pulses look at the next filtered value so flags land on the same edge as filt.
  assign filt = filt_q;
  assign rise = filt_d & ~filt_q;
  assign fall = ~filt_d & filt_q;

endmodule

// File: rtl/inputs_module.sv
// Input buffer: debounced pins, software snapshot, sticky rise/fall flags and a
// registered single-bit read port with read-to-clear of the addressed flags.
module inputs_module
  import rte_io_pkg::*;
#(
  parameter int               WIDTH     = IO_WIDTH,
  parameter int               DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter logic [WIDTH-1:0] SNAP_RST  = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_pins,
  input  logic                     snap_en,
  input  logic                     rd_en,
  input  logic [$clog2(WIDTH)-1:0] addr,
  input  logic                     clr_edges,
  output logic                     val,
  output logic                     edge_bit,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         in_buf,
  output logic                     edge_pending
);

  localparam int ADDR_W = $clog2(WIDTH);

  logic [WIDTH-1:0] filt, rise_p, fall_p;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             val_q, val_d;
  logic             edge_bit_q, edge_bit_d;
  logic             rd_valid_q, rd_valid_d;

  function automatic logic [WIDTH-1:0] bit_mask(input logic [ADDR_W-1:0] a);
    bit_mask    = '0;
    bit_mask[a] = 1'b1;
  endfunction

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    input_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .RST_VAL   (SNAP_RST[i])
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .pin   (in_pins[i]),
      .filt  (filt[i]),
      .rise  (rise_p[i]),
      .fall  (fall_p[i])
    );
  end

  // New edges are OR-ed in after clearing, so a same-cycle set always survives.
  always_comb begin
    clr_mask   = {WIDTH{clr_edges}} | (rd_en ? bit_mask(addr) : '0);
    rise_d     = (rise_q & ~clr_mask) | rise_p;
    fall_d     = (fall_q & ~clr_mask) | fall_p;
    snap_d     = snap_en ? filt : snap_q;
    rd_valid_d = rd_en;
    val_d      = rd_en ? snap_q[addr] : val_q;
    edge_bit_d = rd_en ? (rise_q[addr] | fall_q[addr]) : edge_bit_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q     <= SNAP_RST;
      rise_q     <= '0;
      fall_q     <= '0;
      val_q      <= 1'b0;
      edge_bit_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      snap_q     <= snap_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      val_q      <= val_d;
      edge_bit_q <= edge_bit_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign val          = val_q;
  assign edge_bit     = edge_bit_q;
  assign rd_valid     = rd_valid_q;
  assign in_buf       = snap_q;
  assign edge_pending = |(rise_q | fall_q);

endmodule

// File: tb/tb_inputs_module.sv
// Directed bench for inputs_module; read results are checked through a queue
// of expected {val, edge_bit} pairs pushed when each read is issued.
module tb_inputs_module;
  import rte_io_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_pins;
  logic        snap_en, rd_en, clr_edges;
  logic [4:0]  addr;
  logic        val, edge_bit, rd_valid, edge_pending;
  logic [31:0] in_buf;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  exp_q[$];
  logic [1:0]  exp_pop;

  inputs_module #(
    .WIDTH     (32),
    .DB_CYCLES (4),
    .SNAP_RST  (32'h0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_pins      (in_pins),
    .snap_en      (snap_en),
    .rd_en        (rd_en),
    .addr         (addr),
    .clr_edges    (clr_edges),
    .val          (val),
    .edge_bit     (edge_bit),
    .rd_valid     (rd_valid),
    .in_buf       (in_buf),
    .edge_pending (edge_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a, input logic v, input logic e);
    rd_en = 1'b1;
    addr  = 5'(a);
    exp_q.push_back({v, e});
  endtask

  task automatic snap();
    snap_en = 1'b1;
    tick();
    snap_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL rd_unexpected observed=%b expected=none", {val, edge_bit});
      end else begin
        exp_pop = exp_q.pop_front();
        check("rd_data", {30'b0, val, edge_bit}, {30'b0, exp_pop});
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_pins = 32'hFFFF_FFFF; snap_en = 1'b0;
    rd_en = 1'b0; addr = '0; clr_edges = 1'b0;
    repeat (3) tick();
    check("rst_in_buf",   in_buf,       32'h0);
    check("rst_val",      val,          32'h0);
    check("rst_rd_valid", rd_valid,     32'h0);
    check("rst_edge_bit", edge_bit,     32'h0);
    check("rst_pending",  edge_pending, 32'h0);

    reset = 1'b0;
    repeat (6) tick();
    snap();
    check("post_rst_in_buf",  in_buf,       32'hFFFF_FFFF);
    check("post_rst_pending", edge_pending, 32'h1);

    in_pins = 32'h0;
    repeat (8) tick();
    clr_edges = 1'b1; tick(); clr_edges = 1'b0;
    check("clr_pending", edge_pending, 32'h0);
    snap();
    check("zero_in_buf", in_buf, 32'h0);

    // three-cycle glitch on bit 3 must not reach the filter
    in_pins = 32'h8;
    repeat (3) tick();
    in_pins = 32'h0;
    repeat (10) tick();
    check("glitch_pending", edge_pending, 32'h0);
    snap();
    check("glitch_in_buf", in_buf, 32'h0);

    in_pins = 32'h3;
    repeat (5) tick();
    check("stable_k4_pending", edge_pending, 32'h0);
    tick();
    check("stable_k5_pending", edge_pending, 32'h1);
    snap();
    check("stable_in_buf", in_buf, 32'h3);
    rd(0, 1'b1, 1'b1); tick();
    rd(1, 1'b1, 1'b1); tick();
    rd_en = 1'b0; tick();
    check("stable_rtc_pending", edge_pending, 32'h0);

    in_pins = 32'h8000_0040;
    repeat (8) tick();
    snap();
    check("rdpath_in_buf", in_buf, 32'h8000_0040);
    rd(6, 1'b1, 1'b1);  tick(); check("rdv_1", rd_valid, 32'h1);
    rd(31, 1'b1, 1'b1); tick(); check("rdv_2", rd_valid, 32'h1);
    rd(0, 1'b0, 1'b1);  tick(); check("rdv_3", rd_valid, 32'h1);
    rd_en = 1'b0;       tick(); check("rdv_off", rd_valid, 32'h0);
    tick();
    check("hold_val",      val,      32'h0);
    check("hold_edge_bit", edge_bit, 32'h1);
    rd(6, 1'b1, 1'b0); tick();
    rd(1, 1'b0, 1'b1); tick();
    rd_en = 1'b0; tick();
    check("rdpath_pending", edge_pending, 32'h0);

    // read returns the pre-update snapshot when snap_en coincides
    in_pins = 32'h8000_0044;
    repeat (8) tick();
    snap_en = 1'b1;
    rd(2, 1'b0, 1'b1); tick();
    snap_en = 1'b0;
    rd(2, 1'b1, 1'b0); tick();
    rd_en = 1'b0;
    check("simul_in_buf", in_buf, 32'h8000_0044);

    // read-to-clear of bit 2 on the same edge its fall flag is set
    in_pins = 32'h8000_0040;
    repeat (5) tick();
    rd(2, 1'b1, 1'b0); tick();
    rd_en = 1'b0;
    check("rtc_set_wins_pending", edge_pending, 32'h1);
    tick();
    rd(2, 1'b1, 1'b1); tick();
    rd_en = 1'b0; tick();
    check("rtc_final_pending", edge_pending, 32'h0);

    in_pins = 32'h8000_0060;
    repeat (3) tick();
    check("pre_rst_val", val, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_in_buf",   in_buf,       32'h0);
    check("async_val",      val,          32'h0);
    check("async_edge_bit", edge_bit,     32'h0);
    check("async_rd_valid", rd_valid,     32'h0);
    check("async_pending",  edge_pending, 32'h0);
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();
    check("rerun_k4_pending", edge_pending, 32'h0);
    tick();
    check("rerun_k5_pending", edge_pending, 32'h1);
    snap();
    check("rerun_in_buf", in_buf, 32'h8000_0060);

    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
